// File: rtl/codificador_de_requisicao.sv
// Request encoder: debounces the confirm button, samples and validates the
// User/Func switch pair, and holds an accepted pair on the outputs for a
// fixed window. One request per press; release is required before the next.
`timescale 1ns/1ps
module codificador_de_requisicao #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] SwUser,
   input  logic [2:0] SwFunc,
   input  logic       BtnConfirm,
   output logic [2:0] User,
   output logic [2:0] Func,
   output logic       Valid,
   output logic       Err,
   output logic       Busy
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      ACTIVE,
      WAIT_RELEASE
   } state_t;

   state_t            state;
   logic              sync1;
   logic              sync2;
   logic              btn_s;
   logic [1:0]        primed;
   logic              armed;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              code_ok;

   // Two-flop synchronizer for the raw active-low button; resets to released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= BtnConfirm;
         sync2 <= sync1;
      end
   end

   // Synchronized level, 1 = pressed
   always_comb btn_s = ~sync2;

   // Arming: once the synchronizer carries real samples, a released level must
   // be seen before any press counts, so a button held through reset is ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         primed <= '0;
         armed  <= 1'b0;
      end else begin
         primed <= {primed[0], 1'b1};
         if (primed[1] && !btn_s) begin
            armed <= 1'b1;
         end
      end
   end

   // Pair validation: permitted user codes and a nonzero function code
   always_comb begin
      code_ok = 1'b0;
      case (SwUser)
         3'b001, 3'b011, 3'b101, 3'b110: code_ok = (SwFunc != 3'b000);
         default:                        code_ok = 1'b0;
      endcase
   end

   // Request FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         db_cnt   <= '0;
         hold_cnt <= '0;
         User     <= '0;
         Func     <= '0;
         Valid    <= 1'b0;
         Err      <= 1'b0;
      end else begin
         Err <= 1'b0;
         case (state)
            IDLE: begin
               db_cnt <= '0;
               if (armed && btn_s) begin
                  state  <= DEBOUNCE;
                  db_cnt <= DB_W'(1);
               end
            end
            DEBOUNCE: begin
               if (!btn_s) begin
                  state  <= IDLE;
                  db_cnt <= '0;
               end else if (db_cnt < DB_MAX) begin
                  db_cnt <= db_cnt + DB_W'(1);
               end else begin
                  db_cnt <= '0;
                  if (code_ok) begin
                     state    <= ACTIVE;
                     User     <= SwUser;
                     Func     <= SwFunc;
                     Valid    <= 1'b1;
                     hold_cnt <= HOLD_W'(1);
                  end else begin
                     state <= WAIT_RELEASE;
                     Err   <= 1'b1;
                  end
               end
            end
            ACTIVE: begin
               if (hold_cnt >= HOLD_MAX) begin
                  state    <= WAIT_RELEASE;
                  User     <= '0;
                  Func     <= '0;
                  Valid    <= 1'b0;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            WAIT_RELEASE: begin
               if (!btn_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Busy reflects any non-idle state
   always_comb Busy = (state != IDLE);

endmodule

// File: tb/tb_codificador_de_requisicao.sv
// Self-checking bench for codificador_de_requisicao: an event-level model
// (press run lengths, acceptance timestamps) checked every cycle, plus
// directed scenarios with hand-computed expectations and a random phase.
`timescale 1ns/1ps
module tb_codificador_de_requisicao;

   localparam int D = 4;
   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] SwUser = 3'b000;
   logic [2:0] SwFunc = 3'b000;
   logic       BtnConfirm = 1'b1;
   logic [2:0] User;
   logic [2:0] Func;
   logic       Valid;
   logic       Err;
   logic       Busy;

   codificador_de_requisicao #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES(H)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .SwUser(SwUser),
      .SwFunc(SwFunc),
      .BtnConfirm(BtnConfirm),
      .User(User),
      .Func(Func),
      .Valid(Valid),
      .Err(Err),
      .Busy(Busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Press history as a queue of raw pressed levels; the controller sees each
   // sample two edges later. A press is accepted after D+1 consecutive
   // pressed edges seen while free; the window is timestamped by edge number.
   bit         pq[$];
   int         edge_n;
   int         run;
   int         acc_edge;
   bit         m_active;
   bit         m_need_rel;
   bit         m_armed;
   bit         m_err;
   bit         m_b;
   bit         m_real;
   bit         m_err_next;
   logic [2:0] m_user;
   logic [2:0] m_func;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pq.delete();
         edge_n     = 0;
         run        = 0;
         acc_edge   = 0;
         m_active   = 1'b0;
         m_need_rel = 1'b0;
         m_armed    = 1'b0;
         m_err      = 1'b0;
         m_user     = 3'b000;
         m_func     = 3'b000;
      end else begin
         edge_n++;
         pq.push_back(!BtnConfirm);
         if (pq.size() >= 3) begin
            m_b    = pq[pq.size() - 3];
            m_real = 1'b1;
         end else begin
            m_b    = 1'b0;
            m_real = 1'b0;
         end
         if (pq.size() > 3) void'(pq.pop_front());
         m_err_next = 1'b0;
         if (m_active) begin
            if (edge_n - acc_edge == H) begin
               m_active   = 1'b0;
               m_user     = 3'b000;
               m_func     = 3'b000;
               m_need_rel = 1'b1;
            end
         end else if (m_need_rel) begin
            if (!m_b) m_need_rel = 1'b0;
         end else if (m_b && (run > 0 || m_armed)) begin
            run++;
            if (run == D + 1) begin
               run = 0;
               if ((SwUser inside {3'b001, 3'b011, 3'b101, 3'b110}) && SwFunc != 3'b000) begin
                  m_active = 1'b1;
                  acc_edge = edge_n;
                  m_user   = SwUser;
                  m_func   = SwFunc;
               end else begin
                  m_need_rel = 1'b1;
                  m_err_next = 1'b1;
               end
            end
         end else begin
            run = 0;
         end
         m_err = m_err_next;
         if (m_real && !m_b) m_armed = 1'b1;
      end
   end

   // ---------------- compare + monitor ----------------
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         rise_cnt = 0;
   int         first_u = 0;
   int         first_f = 0;
   int         last_u = 0;
   int         last_f = 0;
   bit         prev_valid = 1'b0;

   always @(negedge clk) begin
      check("User", int'(User), int'(m_user));
      check("Func", int'(Func), int'(m_func));
      check("Valid", int'(Valid), int'(m_active));
      check("Err", int'(Err), int'(m_err));
      check("Busy", int'(Busy), int'(m_active || m_need_rel || (run > 0)));
      if (Valid) valid_cnt++;
      if (Err) err_cnt++;
      if (Valid && !prev_valid) begin
         rise_cnt++;
         if (rise_cnt == 1) begin
            first_u = int'(User);
            first_f = int'(Func);
         end
         last_u = int'(User);
         last_f = int'(Func);
      end
      prev_valid = Valid;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      valid_cnt = 0;
      err_cnt   = 0;
      rise_cnt  = 0;
      first_u   = 0;
      first_f   = 0;
      last_u    = 0;
      last_f    = 0;
   endtask

   task automatic press(input logic [2:0] u, input logic [2:0] f, input int hold, input int rel);
      SwUser     = u;
      SwFunc     = f;
      BtnConfirm = 1'b0;
      repeat (hold) tick();
      BtnConfirm = 1'b1;
      repeat (rel) tick();
   endtask

   // waits for Valid with a cycle budget; returns cycles waited or -1
   task automatic wait_valid(input int t0, output int lat);
      lat = -1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (Valid) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int t0;

      // reset state
      repeat (3) tick();
      check("reset_outputs", int'({User, Func, Valid, Err, Busy}), 0);
      rst_n = 1'b1;
      repeat (5) tick();

      // clean press 101/111
      clear_mon();
      SwUser = 3'b101;
      SwFunc = 3'b111;
      BtnConfirm = 1'b0;
      t0 = cyc;
      wait_valid(t0, lat);
      check("clean_latency", lat, 7);
      repeat (15) tick();
      BtnConfirm = 1'b1;
      repeat (6) tick();
      check("clean_valid_cycles", valid_cnt, 8);
      check("clean_user", first_u, 5);
      check("clean_func", first_f, 7);
      check("clean_err", err_cnt, 0);

      // glitch: 2 cycles low
      clear_mon();
      press(3'b001, 3'b001, 2, 10);
      check("glitch_valid", valid_cnt, 0);
      check("glitch_err", err_cnt, 0);
      check("glitch_busy", int'(Busy), 0);

      // invalid codes
      clear_mon();
      press(3'b010, 3'b001, 10, 5);
      check("inv1_err", err_cnt, 1);
      check("inv1_valid", valid_cnt, 0);
      clear_mon();
      press(3'b110, 3'b000, 10, 5);
      check("inv2_err", err_cnt, 1);
      check("inv2_valid", valid_cnt, 0);

      // hold-over with switch toggling during the window
      clear_mon();
      SwUser = 3'b110;
      SwFunc = 3'b011;
      BtnConfirm = 1'b0;
      wait_valid(cyc, lat);
      check("hold_seen", int'(lat > 0), 1);
      repeat (25) begin
         tick();
         SwFunc = 3'($urandom_range(7));
         SwUser = 3'($urandom_range(7));
      end
      check("hold_windows", rise_cnt, 1);
      check("hold_valid_cycles", valid_cnt, 8);
      check("hold_user", first_u, 6);
      check("hold_func", first_f, 3);
      BtnConfirm = 1'b1;
      repeat (5) tick();

      // back-to-back presses
      clear_mon();
      press(3'b011, 3'b010, 15, 5);
      press(3'b001, 3'b100, 15, 5);
      check("b2b_windows", rise_cnt, 2);
      check("b2b_valid_cycles", valid_cnt, 16);
      check("b2b_first", first_u * 8 + first_f, 3 * 8 + 2);
      check("b2b_second", last_u * 8 + last_f, 1 * 8 + 4);

      // reset mid-hold, button held through reset
      SwUser = 3'b101;
      SwFunc = 3'b011;
      BtnConfirm = 1'b0;
      wait_valid(cyc, lat);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", int'({User, Func, Valid, Err, Busy}), 0);
      tick();
      tick();
      rst_n = 1'b1;
      clear_mon();
      repeat (20) tick();
      check("rst_held_windows", rise_cnt, 0);
      check("rst_held_busy", int'(Busy), 0);
      BtnConfirm = 1'b1;
      repeat (4) tick();
      BtnConfirm = 1'b0;
      repeat (15) tick();
      BtnConfirm = 1'b1;
      repeat (5) tick();
      check("rst_repress_windows", rise_cnt, 1);
      check("rst_repress_user", first_u, 5);

      // random presses, checked cycle by cycle against the model
      repeat (60) begin
         SwUser = 3'($urandom_range(7));
         SwFunc = 3'($urandom_range(7));
         BtnConfirm = 1'b0;
         repeat ($urandom_range(1, 20)) begin
            tick();
            if ($urandom_range(3) == 0) SwFunc = 3'($urandom_range(7));
         end
         BtnConfirm = 1'b1;
         repeat ($urandom_range(1, 6)) tick();
      end

      repeat (12) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
